// File: rtl/sr_ff_arbiter_pkg.sv
// Shared encodings for the SR flip-flop arbiter: FSM states and set/reset op codes.
package sr_ff_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    VERIFY = 2'd2,
    FIN    = 2'd3
  } state_e;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

endpackage

// File: rtl/sr_ff_arbiter_rr.sv
// Combinational round-robin selector: first active request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] sel,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int j_s;

  // priority scan starting at ptr
  always_comb begin
    sel = '0;
    idx = '0;
    any = 1'b0;
    j_s = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j_s = int'(ptr) + k;
      if (j_s >= N_REQ) begin
        j_s = j_s - N_REQ;
      end else begin
        j_s = j_s;
      end
      if (!any && req[j_s]) begin
        any      = 1'b1;
        sel[j_s] = 1'b1;
        idx      = IDX_W'(j_s);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/sr_ff_arbiter.sv
// Grants one requester at a time access to a shared SR flip-flop, pulses s or r
// (never both) and confirms the result on q before signalling done.
module sr_ff_arbiter
  import sr_ff_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int PULSE_W = 2,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_set,
  output logic [N_REQ-1:0] gnt,
  output logic             done,
  output logic             err,
  output logic             s_out,
  output logic             r_out,
  input  logic             q_in
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW    = $clog2(PULSE_W + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             target_q, target_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [TW-1:0]    wcnt_q, wcnt_d;
  logic             errp_q, errp_d;
  logic             done_q, done_d;
  logic             s_q, s_d;
  logic             r_q, r_d;

  logic [N_REQ-1:0] sel_s;
  logic [IDX_W-1:0] idx_s;
  logic             any_s;
  logic             op_s;

  rr_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_rr (
    .req (req),
    .ptr (ptr_q),
    .sel (sel_s),
    .idx (idx_s),
    .any (any_s)
  );

  assign op_s = req_set[idx_s];

  // next-state, counters and s/r pulse generation
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    target_d = target_q;
    ptr_d    = ptr_q;
    pcnt_d   = pcnt_q;
    wcnt_d   = wcnt_q;
    errp_d   = errp_q;
    done_d   = 1'b0;
    s_d      = s_q;
    r_d      = r_q;
    case (state_q)
      IDLE: begin
        s_d = 1'b0;
        r_d = 1'b0;
        if (any_s) begin
          gnt_d    = sel_s;
          target_d = op_s;
          wcnt_d   = '0;
          errp_d   = 1'b0;
          if (idx_s == IDX_W'(N_REQ - 1)) begin
            ptr_d = '0;
          end else begin
            ptr_d = idx_s + IDX_W'(1);
          end
          if (q_in == op_s) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = DRIVE;
            pcnt_d  = PW'(1);
            s_d     = (op_s == OP_SET);
            r_d     = (op_s == OP_RESET);
          end
        end else begin
          gnt_d = '0;
        end
      end
      DRIVE: begin
        if (pcnt_q == PW'(PULSE_W)) begin
          s_d     = 1'b0;
          r_d     = 1'b0;
          state_d = VERIFY;
        end else begin
          pcnt_d = pcnt_q + PW'(1);
        end
      end
      VERIFY: begin
        s_d = 1'b0;
        r_d = 1'b0;
        if (q_in == target_q) begin
          state_d = FIN;
          done_d  = 1'b1;
        end else if (wcnt_q + TW'(1) == TW'(TIMEOUT)) begin
          // counter holds at its limit; the error rides along with done
          state_d = FIN;
          done_d  = 1'b1;
          errp_d  = 1'b1;
        end else begin
          wcnt_d = wcnt_q + TW'(1);
        end
      end
      FIN: begin
        state_d = IDLE;
        gnt_d   = '0;
        errp_d  = 1'b0;
        s_d     = 1'b0;
        r_d     = 1'b0;
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        errp_d  = 1'b0;
        s_d     = 1'b0;
        r_d     = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      target_q <= 1'b0;
      ptr_q    <= '0;
      pcnt_q   <= '0;
      wcnt_q   <= '0;
      errp_q   <= 1'b0;
      done_q   <= 1'b0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      target_q <= target_d;
      ptr_q    <= ptr_d;
      pcnt_q   <= pcnt_d;
      wcnt_q   <= wcnt_d;
      errp_q   <= errp_d;
      done_q   <= done_d;
      s_q      <= s_d;
      r_q      <= r_d;
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign err   = errp_q;
  assign s_out = s_q;
  assign r_out = r_q;

endmodule

// File: tb/tb_sr_ff_arbiter.sv
// Directed bench: arbiter driving a behavioural SR flip-flop with q fed back.
module tb_sr_ff_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] req_set;
  logic [3:0] gnt;
  logic       done, err, s_out, r_out, q_in;
  logic       q_ff = 1'b0;
  logic       force_low = 1'b0;

  int total = 0;
  int bad   = 0;
  int viol  = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  sr_ff_arbiter #(.N_REQ(4), .PULSE_W(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_set(req_set), .gnt(gnt),
    .done(done), .err(err), .s_out(s_out), .r_out(r_out), .q_in(q_in)
  );

  assign q_in = force_low ? 1'b0 : q_ff;

  always @(posedge clk) begin
    if (s_out && !r_out) q_ff <= 1'b1;
    else if (r_out && !s_out) q_ff <= 1'b0;
    else q_ff <= q_ff;
  end

  always @(negedge clk) begin
    if ((s_out & r_out) || !$onehot0(gnt)) viol <= viol + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] set;
    logic [3:0] gnt;
    int         sc;
    int         rc;
    int         lat;
    logic       q;
  } vec_t;

  vec_t vt[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // counts s/r cycles from the current sample until done (inclusive), bounded
  task automatic wait_done(output int lat, output int sc, output int rc, output logic e);
    logic found;
    found = 1'b0;
    lat = 0; sc = 0; rc = 0; e = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (s_out) sc++;
      if (r_out) rc++;
      if (done) begin
        found = 1'b1;
        lat = c;
        e = err;
      end else begin
        step();
      end
    end
    check("done_seen", int'(found), 1);
  endtask

  int lat, sc, rc, d0;
  logic e;

  initial begin
    vt[0] = '{4'b0001, 4'b0001, 4'b0001, 2, 0, 3, 1'b1};
    vt[1] = '{4'b0100, 4'b0000, 4'b0100, 0, 2, 3, 1'b0};
    vt[2] = '{4'b0010, 4'b0000, 4'b0010, 0, 0, 0, 1'b0};
    vt[3] = '{4'b1111, 4'b1010, 4'b0100, 0, 0, 0, 1'b0};
    vt[4] = '{4'b1111, 4'b1010, 4'b1000, 2, 0, 3, 1'b1};
    vt[5] = '{4'b1111, 4'b0101, 4'b0001, 0, 0, 0, 1'b1};
    vt[6] = '{4'b1111, 4'b0101, 4'b0010, 0, 2, 3, 1'b0};
    vt[7] = '{4'b1001, 4'b0000, 4'b1000, 0, 0, 0, 1'b0};
    vt[8] = '{4'b1001, 4'b1111, 4'b0001, 2, 0, 3, 1'b1};

    rst = 1'b1; req = 4'b0000; req_set = 4'b0000;
    step(); step();
    check("rst_gnt", int'(gnt), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_s", int'(s_out), 0);
    check("rst_r", int'(r_out), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      req = vt[i].req; req_set = vt[i].set;
      step();
      check($sformatf("v%0d_gnt", i), int'(gnt), int'(vt[i].gnt));
      req = 4'b0000; req_set = 4'b0000;
      wait_done(lat, sc, rc, e);
      check($sformatf("v%0d_lat", i), lat, vt[i].lat);
      check($sformatf("v%0d_s", i), sc, vt[i].sc);
      check($sformatf("v%0d_r", i), rc, vt[i].rc);
      check($sformatf("v%0d_err", i), int'(e), 0);
      check($sformatf("v%0d_gnt_at_done", i), int'(gnt), int'(vt[i].gnt));
      step();
      check($sformatf("v%0d_gnt_off", i), int'(gnt), 0);
      check($sformatf("v%0d_done_off", i), int'(done), 0);
      check($sformatf("v%0d_q", i), int'(q_ff), int'(vt[i].q));
    end

    // round-robin with all requests held
    rst = 1'b1; step(); rst = 1'b0;
    req = 4'b1111; req_set = 4'b0101;
    for (int k = 0; k < 5; k++) begin
      step();
      wait_done(lat, sc, rc, e);
      check($sformatf("rr%0d_gnt", k), int'(gnt), 1 << (k % 4));
    end
    req = 4'b0000;
    step(); step();

    // verify timeout with q stuck low
    force_low = 1'b1;
    req = 4'b0001; req_set = 4'b0001;
    step();
    check("to_gnt", int'(gnt), 1);
    req = 4'b0000;
    wait_done(lat, sc, rc, e);
    check("to_lat", lat, 10);
    check("to_s", sc, 2);
    check("to_err", int'(e), 1);
    step();
    check("to_done_off", int'(done), 0);
    check("to_err_off", int'(err), 0);

    // reset in the middle of DRIVE restores pointer to 0
    req = 4'b0100; req_set = 4'b0100;
    step();
    check("rd_gnt", int'(gnt), 4);
    check("rd_s_hi", int'(s_out), 1);
    rst = 1'b1; req = 4'b0000;
    step();
    check("rd_s_lo", int'(s_out), 0);
    check("rd_gnt_lo", int'(gnt), 0);
    check("rd_done_lo", int'(done), 0);
    rst = 1'b0; req = 4'b1001; req_set = 4'b1001;
    step();
    check("rd_gnt_after", int'(gnt), 1);
    req = 4'b0000;
    wait_done(lat, sc, rc, e);
    check("rd_err", int'(e), 1);
    step();
    force_low = 1'b0;
    step();

    // dropped request still completes with exactly one done
    d0 = done_cnt;
    req = 4'b0010; req_set = 4'b0000;
    step();
    check("drop_gnt", int'(gnt), 2);
    req = 4'b0000; req_set = 4'b0010;
    wait_done(lat, sc, rc, e);
    check("drop_r", rc, 2);
    check("drop_s", sc, 0);
    for (int k = 0; k < 5; k++) step();
    check("drop_done_cnt", done_cnt - d0, 1);
    check("drop_q", int'(q_ff), 0);

    check("invariants", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
